// File: rtl/parity_word_sequencer.sv
// parity_word_sequencer
//
// Feeds the 7-input Davio parity unit and checks its answer. Serial bits
// (LSB first) are collected into a 7-bit word and driven onto D. After
// SETTLE cycles the unit's F output is sampled and compared against the
// XOR reduction of the word. The word, the sampled parity and the error
// flag are presented on a valid/ready result port. Saturating counters
// track results handed off and results handed off with an error.
//
// Optional build macro: PARITY_ERR_INJ_EN
//   When defined, adds input inj_err. If inj_err is high in the sampling
//   cycle, the sampled F is inverted before it is stored and compared, so
//   the checker path can be exercised with a healthy parity unit.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   s_valid    serial bit valid
//   s_ready    sequencer can accept a serial bit
//   s_bit      serial data bit, LSB of word first
//   D[6:0]     word driven to the parity unit
//   F          parity unit result
//   inj_err    (PARITY_ERR_INJ_EN only) invert sampled F
//   m_valid    result available
//   m_ready    consumer accepts result
//   m_word     evaluated word
//   m_parity   sampled (possibly injected) F
//   m_err      sampled F differs from golden parity
//   word_count results handed off (saturating)
//   err_count  results handed off with m_err=1 (saturating)
//
// State     | meaning
// ----------+-----------------------------------------------------------
// COLLECT   | accepting serial bits into the shift register
// EVAL      | D held stable, waiting SETTLE cycles, then sample F
// HOLD      | result presented on m_*, waiting for m_ready

module parity_word_sequencer #(
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_bit,
    output logic [6:0]       D,
    input  logic             F,
`ifdef PARITY_ERR_INJ_EN
    input  logic             inj_err,
`endif
    output logic             m_valid,
    input  logic             m_ready,
    output logic [6:0]       m_word,
    output logic             m_parity,
    output logic             m_err,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EVAL    = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // Sampling happens in the EVAL cycle where the counter reaches this value.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       shift_q, shift_d;
    logic [6:0]       d_q, d_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic             m_valid_q, m_valid_d;
    logic [6:0]       m_word_q, m_word_d;
    logic             m_parity_q, m_parity_d;
    logic             m_err_q, m_err_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             f_eff;

`ifdef PARITY_ERR_INJ_EN
    assign f_eff = F ^ inj_err;
`else
    assign f_eff = F;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_COLLECT;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            d_q          <= '0;
            settle_cnt_q <= '0;
            m_valid_q    <= 1'b0;
            m_word_q     <= '0;
            m_parity_q   <= 1'b0;
            m_err_q      <= 1'b0;
            word_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            d_q          <= d_d;
            settle_cnt_q <= settle_cnt_d;
            m_valid_q    <= m_valid_d;
            m_word_q     <= m_word_d;
            m_parity_q   <= m_parity_d;
            m_err_q      <= m_err_d;
            word_count_q <= word_count_d;
            err_count_q  <= err_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        d_d          = d_q;
        settle_cnt_d = settle_cnt_q;
        m_valid_d    = m_valid_q;
        m_word_d     = m_word_q;
        m_parity_d   = m_parity_q;
        m_err_d      = m_err_q;
        word_count_d = word_count_q;
        err_count_d  = err_count_q;
        s_ready      = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (bit_cnt_q == 3'd6) begin
                        // Last bit goes straight onto D; the shift register
                        // is cleared so nothing stale survives into the next word.
                        d_d          = {s_bit, shift_q[5:0]};
                        shift_d      = '0;
                        bit_cnt_d    = '0;
                        settle_cnt_d = '0;
                        state_d      = ST_EVAL;
                    end else begin
                        shift_d[bit_cnt_q] = s_bit;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                    end
                end
            end

            ST_EVAL: begin
                settle_cnt_d = settle_cnt_q + 4'd1;
                if (settle_cnt_q == SETTLE_LAST) begin
                    m_word_d   = d_q;
                    m_parity_d = f_eff;
                    m_err_d    = f_eff ^ (^d_q);
                    m_valid_d  = 1'b1;
                    state_d    = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    if (word_count_q != '1) begin
                        word_count_d = word_count_q + CNT_W'(1);
                    end
                    if (m_err_q && (err_count_q != '1)) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                    bit_cnt_d = '0;
                    state_d   = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    assign D          = d_q;
    assign m_valid    = m_valid_q;
    assign m_word     = m_word_q;
    assign m_parity   = m_parity_q;
    assign m_err      = m_err_q;
    assign word_count = word_count_q;
    assign err_count  = err_count_q;

endmodule
